// File: rtl/dm_arbiter.sv
// Single-port data memory arbiter between the pipeline and the debug/loader port.
// Define DM_ARB_STARVE_GUARD_EN to build the debug starvation guard (starve_cnt).
module dm_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_we,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              stall_pipe,
    output logic [1:0]        dbg_state,
    output logic [3:0]        dbg_starve_cnt
);

    // Handshake: a port's request is accepted in the same cycle its gnt is high;
    // a granted read returns rvalid/rdata on that port exactly one cycle later.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD_P = 2'd1;
    localparam logic [1:0] RD_D = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;

`ifdef DM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;

    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (p_req && d_req) begin
                if (starve_cnt == LIMIT) d_gnt = 1'b1;
                else                     p_gnt = 1'b1;
            end else begin
                p_gnt = p_req;
                d_gnt = d_req;
            end
        end
    end

    // Counts pipeline wins while debug waits; saturates so debug wins next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (d_gnt || !d_req) begin
            starve_cnt <= 4'd0;
        end else if (p_gnt && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    assign dbg_starve_cnt = starve_cnt;
`else
    always_comb begin
        p_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            p_gnt = p_req;
            d_gnt = d_req && !p_req;
        end
    end

    assign dbg_starve_cnt = 4'd0;
`endif

    always_comb begin
        mem_en   = p_gnt || d_gnt;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (p_gnt) begin
            mem_we   = p_we;
            mem_addr = p_addr;
            mem_din  = p_wdata;
        end else if (d_gnt) begin
            mem_we   = d_we;
            mem_addr = d_addr;
            mem_din  = d_wdata;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        if (p_gnt && !p_we)      state_nxt = RD_P;
        else if (d_gnt && !d_we) state_nxt = RD_D;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    assign p_rvalid   = (state == RD_P);
    assign d_rvalid   = (state == RD_D);
    assign p_rdata    = p_rvalid ? mem_dout : '0;
    assign d_rdata    = d_rvalid ? mem_dout : '0;
    assign stall_pipe = p_req && !p_gnt;
    assign dbg_state  = state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural single-port memory.
// Starvation expectations follow DM_ARB_STARVE_GUARD_EN.
module tb_dm_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          p_req = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic          p_gnt, p_rvalid;
  logic [DW-1:0] p_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          stall_pipe;
  logic [1:0]    dbg_state;
  logic [3:0]    dbg_starve_cnt;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .stall_pipe(stall_pipe),
    .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  // synchronous single-port memory, preloaded while reset is high
  always @(posedge clk) begin
    if (reset) begin
      mem[8'h10] <= 8'hA5;
      mem[8'h01] <= 8'h11;
      mem[8'h02] <= 8'h22;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      else        mem_dout <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance one cycle, apply inputs just after the edge, settle before checks
  task automatic cyc(input logic pr, input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                     input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(posedge clk);
    #1;
    p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
    #3;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_resp(input string tag, input logic ep, input logic ed, input logic [DW-1:0] data);
    check({tag, "_p_rvalid"}, 32'(p_rvalid), 32'(ep));
    check({tag, "_d_rvalid"}, 32'(d_rvalid), 32'(ed));
    check({tag, "_p_rdata"}, 32'(p_rdata), ep ? 32'(data) : 32'h0);
    check({tag, "_d_rdata"}, 32'(d_rdata), ed ? 32'(data) : 32'h0);
  endtask

  initial begin
    logic exp_d;
    logic prev_d;
    logic [DW-1:0] exp_data;

    // reset state, with a pipeline request pending
    repeat (2) @(posedge clk);
    #1;
    p_req = 1'b1;
    #3;
    check("rst_p_gnt", 32'(p_gnt), 32'h0);
    check("rst_d_gnt", 32'(d_gnt), 32'h0);
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    check("rst_starve", 32'(dbg_starve_cnt), 32'h0);
    check_resp("rst", 1'b0, 1'b0, '0);
    #2;
    @(posedge clk);
    #1;
    reset = 1'b0;
    p_req = 1'b0;

    // pipeline read of 0x10
    cyc(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, '0, '0);
    check("prd_p_gnt", 32'(p_gnt), 32'h1);
    check("prd_d_gnt", 32'(d_gnt), 32'h0);
    check("prd_mem_en", 32'(mem_en), 32'h1);
    check("prd_mem_we", 32'(mem_we), 32'h0);
    check("prd_mem_addr", 32'(mem_addr), 32'h10);
    check("prd_stall", 32'(stall_pipe), 32'h0);
    idle();
    check_resp("prd", 1'b1, 1'b0, 8'hA5);
    check("idle_mem_en", 32'(mem_en), 32'h0);
    check("idle_mem_addr", 32'(mem_addr), 32'h0);
    check("idle_mem_din", 32'(mem_din), 32'h0);

    // debug write 0x3C to 0x20, then pipeline read back
    cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h20, 8'h3C);
    check("dwr_d_gnt", 32'(d_gnt), 32'h1);
    check("dwr_p_gnt", 32'(p_gnt), 32'h0);
    check("dwr_mem_we", 32'(mem_we), 32'h1);
    check("dwr_mem_addr", 32'(mem_addr), 32'h20);
    check("dwr_mem_din", 32'(mem_din), 32'h3C);
    cyc(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, '0, '0);
    check_resp("dwr", 1'b0, 1'b0, '0);
    check("rb_p_gnt", 32'(p_gnt), 32'h1);
    idle();
    check_resp("rb", 1'b1, 1'b0, 8'h3C);

    // alternating pipeline read 0x01 / debug read 0x02, one per cycle
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        cyc(1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, '0, '0);
        check($sformatf("alt%0d_p_gnt", k), 32'(p_gnt), 32'h1);
        if (k > 0) check_resp($sformatf("alt%0d", k), 1'b0, 1'b1, exp_q.pop_front());
        exp_q.push_back(8'h11);
      end else begin
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h02, 8'h00);
        check($sformatf("alt%0d_d_gnt", k), 32'(d_gnt), 32'h1);
        check_resp($sformatf("alt%0d", k), 1'b1, 1'b0, exp_q.pop_front());
        exp_q.push_back(8'h22);
      end
    end
    idle();
    check_resp("alt_end", 1'b0, 1'b1, exp_q.pop_front());

    // both ports requesting reads continuously
    prev_d = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
`ifdef DM_ARB_STARVE_GUARD_EN
      exp_d = (i % 5 == 0);
      check($sformatf("stv%0d_cnt", i), 32'(dbg_starve_cnt), 32'((i - 1) % 5));
`else
      exp_d = 1'b0;
      check($sformatf("stv%0d_cnt", i), 32'(dbg_starve_cnt), 32'h0);
`endif
      check($sformatf("stv%0d_p_gnt", i), 32'(p_gnt), 32'(!exp_d));
      check($sformatf("stv%0d_d_gnt", i), 32'(d_gnt), 32'(exp_d));
      check($sformatf("stv%0d_stall", i), 32'(stall_pipe), 32'(exp_d));
      if (i > 1) begin
        exp_data = prev_d ? 8'h22 : 8'hA5;
        check_resp($sformatf("stv%0d", i), !prev_d, prev_d, exp_data);
      end
      prev_d = exp_d;
    end

    // pipeline read granted, then reset in the following cycle
    idle();
    cyc(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, '0, '0);
    check("rif_p_gnt", 32'(p_gnt), 32'h1);
    @(posedge clk);
    reset = 1'b1;
    #4;
    check("rif_rst_p_rvalid", 32'(p_rvalid), 32'h0);
    check("rif_rst_state", 32'(dbg_state), 32'h0);
    check("rif_rst_starve", 32'(dbg_starve_cnt), 32'h0);
    check("rif_rst_p_gnt", 32'(p_gnt), 32'h0);
    check("rif_rst_mem_en", 32'(mem_en), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    p_req = 1'b0;
    #3;
    check_resp("rif_rel", 1'b0, 1'b0, '0);
    idle();
    check_resp("rif_after", 1'b0, 1'b0, '0);
    check("rif_after_state", 32'(dbg_state), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter STARVE_LIMIT, default 4, maximum consecutive pipeline grants while the debug port waits (range 1-15).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 p_req, p_we  input  1 each  pipeline access request; write when 1.
REQ-008 p_addr / p_wdata  input  ADDR_W / DATA_W  pipeline address and write data.
REQ-009 p_gnt, p_rvalid  output  1 each  pipeline grant; pipeline read data valid.
REQ-010 p_rdata  output  DATA_W  pipeline read data.
REQ-011 d_req, d_we, d_addr, d_wdata  input  1/1/ADDR_W/DATA_W  debug/loader port request, same meaning as the pipeline port.
REQ-012 d_gnt, d_rvalid, d_rdata  output  1/1/DATA_W  debug grant, read valid, read data.
REQ-013 mem_en, mem_we  output  1 each  enable and write enable to the single-port synchronous data memory.
REQ-014 mem_addr / mem_din  output  ADDR_W / DATA_W  memory address and write data.
REQ-015 mem_dout  input  DATA_W  memory read data, valid one cycle after an enabled read.
REQ-016 stall_pipe  output  1  asserted when p_req=1 and p_gnt=0.

Function
REQ-017 Grant SHALL be combinational within the request cycle: at most one of p_gnt/d_gnt high; a grant is never given without the matching req.
REQ-018 Only p_req high: p_gnt=1. Only d_req high: d_gnt=1. Neither: no grant, mem_en=0.
REQ-019 Both high: pipeline wins, unless starve_cnt equals STARVE_LIMIT, in which case debug wins.
REQ-020 starve_cnt (4 bits) SHALL increment when p_gnt=1 and d_req=1, clear when d_gnt=1 or d_req=0, and saturate at STARVE_LIMIT.
REQ-021 The granted port's we/addr/wdata SHALL drive mem_we/mem_addr/mem_din in the same cycle with mem_en=1; with no grant, mem_we=0 and mem_addr/mem_din=0.
REQ-022 A granted read SHALL register the owner (state RD_P or RD_D, else IDLE); next cycle the owner's rvalid=1 and rdata=mem_dout; the other port's rdata=0.
REQ-023 Read latency SHALL be exactly 1 cycle; a write produces no rvalid.
REQ-024 Back-to-back grants (read then read, read then write, either port) SHALL be accepted every cycle without bubbles.
REQ-025 Owner state transitions: any state -> RD_P on a granted pipeline read, RD_D on a granted debug read, IDLE otherwise.
REQ-026 stall_pipe SHALL equal p_req AND NOT p_gnt.

Reset
REQ-027 While reset=1, state=IDLE, starve_cnt=0, p_rvalid=d_rvalid=0, and p_rdata=d_rdata=0, asynchronously.
REQ-028 Reset asserted with a read in flight SHALL drop that read: no rvalid is produced after reset releases.
REQ-029 Grants during reset SHALL be 0 and mem_en=0.

Configuration
REQ-030 Macro DM_ARB_STARVE_GUARD_EN: when defined, starve_cnt and REQ-019/020 forced-debug arbitration SHALL be present.
REQ-031 When DM_ARB_STARVE_GUARD_EN is undefined, the pipeline SHALL have strict priority, no counter SHALL be built, and debug is granted only when p_req=0.

Verification
REQ-032 p_req=1, p_we=0, p_addr=0x10 with memory[0x10]=0xA5 -> p_gnt=1 same cycle; p_rvalid=1, p_rdata=0xA5 next cycle; d_rvalid=0.
REQ-033 d_req=1, d_we=1, d_addr=0x20, d_wdata=0x3C, p_req=0 -> d_gnt=1, mem_we=1, mem_addr=0x20; a later pipeline read of 0x20 returns 0x3C.
REQ-034 Guard enabled, STARVE_LIMIT=4, p_req and d_req held high -> p_gnt for 4 cycles, d_gnt in cycle 5, stall_pipe=1 in cycle 5, then the pattern repeats.
REQ-035 Guard disabled, same stimulus as REQ-034 -> d_gnt never asserts while p_req=1.
REQ-036 Pipeline read granted, reset pulsed in the following cycle -> p_rvalid=0 throughout and after release; state=IDLE, starve_cnt=0.
REQ-037 Alternating pipeline read 0x01 and debug read 0x02 every cycle -> each rvalid on the correct port one cycle later with matching data, no lost cycles.
